// File: rtl/pipelined_cla_addsub.sv
// WIDTH-bit adder/subtractor built from 4-bit carry-look-ahead groups, one group per pipeline stage.
// The inter-group carry is registered, so the critical path is a single 4-bit CLA regardless of WIDTH.
module pipelined_cla_addsub #(
   parameter int WIDTH = 16,
   parameter int GROUP = 4
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             mode_i,
   input  logic             cin_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] sum_o,
   output logic             cout_o,
   output logic             ovf_o,
   output logic             zero_o
);

   localparam int NGRP = WIDTH / GROUP;

   // Returns {carry into bit 3, carry out of bit 3, sum[3:0]}.
   function automatic logic [5:0] cla4(input logic [3:0] x, input logic [3:0] y, input logic c0);
      logic [3:0] g;
      logic [3:0] p;
      logic       c1, c2, c3, c4;
      g  = x & y;
      p  = x ^ y;
      c1 = g[0] | (p[0] & c0);
      c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
      c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
      c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c0);
      return {c3, c4, p ^ {c3, c2, c1, c0}};
   endfunction

   logic [WIDTH-1:0] a_q   [NGRP];
   logic [WIDTH-1:0] bx_q  [NGRP];
   logic [WIDTH-1:0] sum_q [NGRP];
   logic [NGRP-1:0]  v_q;
   logic [NGRP-1:0]  c_q;
   logic             ovf_q;
   logic             zero_q;

   logic [WIDTH-1:0] st_a  [NGRP];
   logic [WIDTH-1:0] st_b  [NGRP];
   logic [WIDTH-1:0] st_s  [NGRP];
   logic [NGRP-1:0]  st_c;
   logic [NGRP-1:0]  st_v;
   logic [5:0]       grp   [NGRP];
   logic [WIDTH-1:0] sum_d [NGRP];
   logic [NGRP-1:0]  c_d;
   logic             ovf_d;
   logic             zero_d;
   logic             advance;

   // A stalled output freezes every stage; bubbles still shift when the output is free.
   assign advance     = !v_q[NGRP-1] | out_ready_i;
   assign in_ready_o  = !rst_n_i | advance;
   assign out_valid_o = v_q[NGRP-1];
   assign sum_o       = sum_q[NGRP-1];
   assign cout_o      = c_q[NGRP-1];
   assign ovf_o       = ovf_q;
   assign zero_o      = zero_q;

   always_comb begin
      // Subtract is a + ~b + 1: B is inverted and the carry forced high on capture.
      st_a[0] = a_i;
      st_b[0] = mode_i ? ~b_i : b_i;
      st_s[0] = '0;
      st_c[0] = mode_i | cin_i;
      st_v[0] = in_valid_i;
      for (int k = 1; k < NGRP; k++) begin
         st_a[k] = a_q[k-1];
         st_b[k] = bx_q[k-1];
         st_s[k] = sum_q[k-1];
         st_c[k] = c_q[k-1];
         st_v[k] = v_q[k-1];
      end
      for (int k = 0; k < NGRP; k++) begin
         grp[k]   = cla4(st_a[k][GROUP*k +: GROUP], st_b[k][GROUP*k +: GROUP], st_c[k]);
         sum_d[k] = st_s[k];
         sum_d[k][GROUP*k +: GROUP] = grp[k][3:0];
         c_d[k]   = grp[k][4];
      end
      ovf_d  = grp[NGRP-1][5] ^ grp[NGRP-1][4];
      zero_d = (sum_d[NGRP-1] == '0);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         v_q    <= '0;
         c_q    <= '0;
         ovf_q  <= 1'b0;
         zero_q <= 1'b0;
         for (int k = 0; k < NGRP; k++) begin
            a_q[k]   <= '0;
            bx_q[k]  <= '0;
            sum_q[k] <= '0;
         end
      end else if (advance) begin
         v_q <= st_v;
         // Data registers only load for valid stages, so results hold across bubbles.
         for (int k = 0; k < NGRP; k++) begin
            if (st_v[k]) begin
               a_q[k]   <= st_a[k];
               bx_q[k]  <= st_b[k];
               sum_q[k] <= sum_d[k];
               c_q[k]   <= c_d[k];
            end
         end
         if (st_v[NGRP-1]) begin
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
         end
      end
   end

endmodule

// File: doc/pipelined_cla_addsub.md
Name: pipelined_cla_addsub

Overview:
- Parametrised WIDTH-bit adder/subtractor built from 4-bit carry-look-ahead groups.
- One group is evaluated per pipeline stage. The inter-group carry is registered between stages, so timing is independent of WIDTH.
- Valid/ready handshake on input and output gives full throughput (one operation per cycle) with backpressure.
- Datapath ALU building block; successor to the single 4-bit CLA carry generator.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of GROUP and at least GROUP.
- GROUP, 4, bits per CLA group; fixed at 4 in this generation, other values are illegal.
- NGRP, WIDTH/GROUP, derived; pipeline depth in cycles (not user-overridable).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  input operation present.
- in_ready  out  1  block can accept the input this cycle.
- a  in  WIDTH  operand A (two's complement or unsigned).
- b  in  WIDTH  operand B.
- mode  in  1  0 = add, 1 = subtract.
- cin  in  1  carry-in, used in add mode only.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts the result.
- sum  out  WIDTH  result.
- cout  out  1  carry out of the MSB; in subtract mode, 1 = no borrow.
- ovf  out  1  signed overflow.
- zero  out  1  sum == 0.

Behaviour:
- Operation:
  - add: sum = a + b + cin.
  - sub: sum = a + ~b + 1, with cin ignored; this is the Select-as-carry-in scheme.
  - B inversion and carry-in selection happen at stage 0 capture.
- Per group i: g = a_i & b'_i, p = a_i ^ b'_i. Group carries are c1..c4 using the standard CLA equations from the group carry-in. Sum bits are p ^ {c3..c0}.
- Stage k (k = 0..NGRP-1) computes group k from the carry registered by stage k-1. Stage 0 uses the mode/cin carry.
- Each stage registers:
  - the computed sum bits;
  - the carry out;
  - the still-unprocessed upper bits of a and b' (after inversion);
  - a valid bit.
- Latency: exactly NGRP cycles from the input handshake (in_valid & in_ready) to out_valid, when there is no stall.
- Throughput: one operation per cycle, with back-to-back inputs allowed.
- Flags, registered with the last stage:
  - cout = carry out of the top group.
  - ovf = carry into the MSB XOR carry out of the MSB.
  - zero = (sum == 0).
- Handshake:
  - in_ready = !out_valid | out_ready.
  - When out_valid & !out_ready, the whole pipeline freezes: no register changes and no bubbles are compressed.
  - The output is consumed when out_valid & out_ready.
  - sum/cout/ovf/zero stay stable while out_valid & !out_ready.
  - Bubbles (in_valid = 0) propagate as valid = 0 stages and do not stall.
- Reset (rst_n = 0 sampled at a rising edge):
  - All stage valid bits clear; sum, cout, ovf and zero = 0; out_valid = 0.
  - in_ready = 1 in the first cycle after reset.
  - Reset mid-operation discards all in-flight operations; no partial result is emitted.
  - While rst_n = 0, in_ready = 1 but inputs are dropped.
- Wrap-around: the result is modulo 2^WIDTH. Carry beyond the MSB is reported only on cout.
- When out_valid = 0, the values of sum and flags are don't-care for the bench; the implementation holds the last values.

Test Plan:
- Add, WIDTH=16: a=0x1234, b=0x4321, cin=0 -> after 4 cycles sum=0x5555, cout=0, ovf=0, zero=0.
- Carry chain across all groups: add a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1, ovf=0, zero=1. Then add a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1.
- Subtract:
  - 0x0005-0x0007 -> sum=0xFFFE, cout=0, ovf=0.
  - 0x8000-0x0001 -> sum=0x7FFF, cout=1, ovf=1.
  - 0x1234-0x1234 with cin=1 (must be ignored) -> sum=0, cout=1, zero=1.
- Throughput and backpressure:
  - Drive 8 back-to-back random ops with out_ready=1 -> 8 consecutive out_valid cycles in order, matching the reference model.
  - Repeat with out_ready=0 for 3 cycles mid-stream -> in_ready=0 for those cycles, outputs held stable, no loss or duplication.
- Reset mid-operation: issue 3 ops, assert rst_n=0 for one cycle after the 2nd cycle -> out_valid stays 0. The next op after reset emerges 4 cycles after its handshake with the correct result.
- Parameter sweep: WIDTH=4 (latency 1) and WIDTH=32 (latency 8) -> a=all-ones, b=1, add -> sum=0, cout=1, at the stated latency.
